mem_req_ctrl: RTL and testbench

Request sequencer that sits directly upstream of the 4-entry × 8-bit memory and drives its bus: addr, wr_en, rd_en and wdata, with rdata returned. Accepts write/read commands from a producer over a valid/ready handshake and buffers them in a small command FIFO. Issues them to the memory one at a time and returns read data in order over a valid/ready response channel. Replaces direct pin-driving of the memory when multiple back-to-back commands must be queued.

---
 rtl/mem_req_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: command sequencer in front of a small synchronous memory.
// Producer commands are queued in a DEPTH-entry FIFO, then issued to the
// memory one at a time. Read data returns in command order on a valid/ready
// response channel. All memory-side and response outputs are registered.
// Optional: define MEM_REQ_CTRL_STATS_EN to add saturating wr_cnt/rd_cnt
// counters of issued write and read strobes.
module mem_req_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
`ifdef MEM_REQ_CTRL_STATS_EN
    ,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
`endif
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CAP,
        S_RSP
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ENTRY_W-1:0]  fifo_mem_q [DEPTH];

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                push;
    logic                pop;
    logic [ENTRY_W-1:0]  head;
    logic                head_wr;
    logic [ADDR_W-1:0]   head_addr;
    logic [DATA_W-1:0]   head_data;

    // Ready comes from the registered count only; held low while reset is asserted.
    assign req_ready = reset && (count_q != CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

    assign head      = fifo_mem_q[rd_ptr_q];
    assign head_wr   = head[ENTRY_W-1];
    assign head_addr = head[DATA_W +: ADDR_W];
    assign head_data = head[DATA_W-1:0];

    // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents are don't-care once flushed, so no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {req_wr, req_addr, req_wdata};
    end

    // Issue FSM: strobes are computed one cycle ahead so they leave a flop.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    addr_d = head_addr;
                    if (head_wr) begin
                        wdata_d = head_data;
                        wr_en_d = 1'b1;
                        state_d = S_WR;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = S_RD;
                    end
                end
            end
            S_WR:  state_d = S_IDLE;
            S_RD:  state_d = S_CAP;
            S_CAP: begin
                // Memory returns data the cycle after rd_en.
                rsp_rdata_d = rdata;
                rsp_addr_d  = addr_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, FIFO control and registered outputs; reset flushes everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_REQ_CTRL_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;

    // Saturating strobe counters, bumped in the cycle each strobe is high.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_en_q && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
        if (rd_en_q && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: directed timing checks plus a randomized
// command stream scored against an in-order memory reference model.
module tb_mem_req_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [1:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [1:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] rdata = '0;
`ifdef MEM_REQ_CTRL_STATS_EN
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
`endif

    mem_req_ctrl #(.DEPTH(4), .ADDR_W(2), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata), .rdata(rdata)
`ifdef MEM_REQ_CTRL_STATS_EN
        , .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory attached to the bus: synchronous write, read data one cycle after rd_en.
    logic [7:0] tmem [4];
    initial for (int i = 0; i < 4; i++) tmem[i] = '0;
    always @(posedge clk) begin
        if (wr_en) tmem[addr] <= wdata;
        if (rd_en) rdata <= tmem[addr];
    end

    typedef struct {
        bit       wr;
        bit [1:0] addr;
        bit [7:0] data;
    } cmd_t;

    // Reference: commands take effect in acceptance order, one at a time.
    bit [7:0] mem_ref [4];
    cmd_t     iss_q[$];
    cmd_t     rsp_q[$];
    int       exp_wr = 0, exp_rd = 0;
    int       n_cmp = 0, n_err = 0;
    bit       stop_rnd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_accept(input bit w, input bit [1:0] a, input bit [7:0] d);
        cmd_t c;
        c.wr = w; c.addr = a; c.data = d;
        iss_q.push_back(c);
        if (w) begin
            mem_ref[a] = d;
            exp_wr++;
        end else begin
            c.data = mem_ref[a];
            rsp_q.push_back(c);
            exp_rd++;
        end
    endfunction

    // Bus and response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (wr_en && rd_en) chk("strobe_excl", 1, 0);
            if (wr_en || rd_en) begin
                if (iss_q.size() == 0) chk("iss_unexpected", 1, 0);
                else begin
                    cmd_t e;
                    e = iss_q.pop_front();
                    chk("iss_wr", wr_en, e.wr);
                    chk("iss_addr", addr, e.addr);
                    if (e.wr) chk("iss_wdata", wdata, e.data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    cmd_t e;
                    e = rsp_q.pop_front();
                    chk("rsp_addr", rsp_addr, e.addr);
                    chk("rsp_rdata", rsp_rdata, e.data);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input bit w, input bit [1:0] a, input bit [7:0] d);
        int n = 0;
        req_valid = 1'b1; req_wr = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("push_timeout", 0, 1);
        else model_accept(w, a, d);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Asserts reset now, checks reset values, releases after one reset edge.
    task automatic do_reset();
        reset = 1'b0;
        iss_q.delete();
        rsp_q.delete();
        exp_wr = 0; exp_rd = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wdata", wdata, 0);
`ifdef MEM_REQ_CTRL_STATS_EN
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_rd_cnt", rd_cnt, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while ((iss_q.size() != 0 || rsp_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_done", (iss_q.size() == 0 && rsp_q.size() == 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem_ref[i] = '0;
        do_reset();

        // Single write: strobe exactly one cycle after acceptance.
        push(1, 2'd2, 8'hA5);
        @(negedge clk);
        chk("wr_lat_e0", wr_en, 0);
        @(negedge clk);
        chk("wr_lat_en", wr_en, 1);
        chk("wr_lat_addr", addr, 2);
        chk("wr_lat_data", wdata, 8'hA5);
        chk("wr_no_rsp", rsp_valid, 0);
        drain();

        // Write then read of the same address; read latency from an idle FIFO.
        push(1, 2'd1, 8'h3C);
        drain();
        push(0, 2'd1, 8'h00);
        @(negedge clk); chk("rd_lat_e0", rd_en, 0);
        @(negedge clk); chk("rd_lat_en", rd_en, 1);
        @(negedge clk); chk("rd_lat_cap", rsp_valid, 0); chk("rd_cap_strobe", rd_en, 0);
        @(negedge clk); chk("rd_lat_rsp", rsp_valid, 1);
        chk("rd_rsp_addr", rsp_addr, 1);
        chk("rd_rsp_data", rsp_rdata, 8'h3C);
        drain();

        // Back-to-back fill across the pointer wrap, then ordered reads.
        push(1, 2'd0, 8'h11); push(1, 2'd1, 8'h22);
        push(1, 2'd2, 8'h33); push(1, 2'd3, 8'h44);
        for (int i = 0; i < 4; i++) push(0, 2'(i), 8'h00);
        drain();

        // Stalled consumer: FIFO fills to DEPTH, a held request waits.
        rsp_ready = 1'b0;
        push(0, 2'd3, 8'h00);
        push(1, 2'd0, 8'h5A); push(0, 2'd0, 8'h00);
        push(1, 2'd2, 8'hC3); push(0, 2'd2, 8'h00);
        @(negedge clk);
        chk("full_ready_low", req_ready, 0);
        chk("full_rsp_held", rsp_valid, 1);
        chk("full_rsp_addr", rsp_addr, 3);
        fork
            push(0, 2'd1, 8'h00);
            begin
                repeat (4) @(negedge clk);
                chk("full_still_low", req_ready, 0);
                chk("full_rsp_stable", rsp_rdata, 8'h44);
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        drain();

        // Reset while a read is in its capture cycle.
        push(0, 2'd3, 8'h00);
        begin
            int n = 0;
            @(negedge clk);
            while (!rd_en && n < 20) begin @(negedge clk); n++; end
            chk("cap_rd_seen", rd_en, 1);
        end
        @(posedge clk); #1;
        do_reset();
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
            chk("post_rst_no_rd", rd_en, 0);
        end
        @(posedge clk); #1;

`ifdef MEM_REQ_CTRL_STATS_EN
        push(1, 2'd0, 8'h01); push(1, 2'd1, 8'h02); push(1, 2'd2, 8'h03);
        push(0, 2'd0, 8'h00); push(0, 2'd2, 8'h00);
        drain();
        chk("stats_wr", wr_cnt, 3);
        chk("stats_rd", rd_cnt, 2);
        do_reset();
`endif

        // Randomized stream with a randomly stalling consumer.
        stop_rnd = 0;
        fork
            while (!stop_rnd) begin
                @(posedge clk); #1;
                if (!stop_rnd) rsp_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int i = 0; i < 250; i++) begin
            push($urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end
        stop_rnd = 1;
        @(posedge clk); #2;
        drain();
`ifdef MEM_REQ_CTRL_STATS_EN
        chk("rnd_stats_wr", wr_cnt, exp_wr);
        chk("rnd_stats_rd", rd_cnt, exp_rd);
`endif
        chk("final_idle_rsp", rsp_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
